// File: rtl/shift_divider_if.sv
// Load/operand/result bundle between the shift divider and its controller.
// The controller side drives the operands; the divider drives results and status.
interface shift_divider_if #(
    parameter int N = 6
);
    logic           load;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output load, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  load, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/shift_divider.sv
// Restoring shift-subtract divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient and remainder in N steps, with divide-by-zero and overflow shortcuts.
module shift_divider #(
    parameter int N = 6
) (
    input  logic            clk,
    input  logic            reset,
    shift_divider_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   qw_q, qw_d;
    logic [N-1:0]   d_q, d_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [N:0]     r_sh;
    logic [N-1:0]   t;
    logic           fits;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        qw_d    = qw_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        // R stays below D between steps, so the stored N bits plus the bit
        // shifted in from Q form the full N+1-bit partial remainder; when the
        // subtraction fits, the difference is below D and the low N bits suffice.
        r_sh = {r_q, qw_q[N-1]};
        fits = (r_sh >= {1'b0, d_q});
        t    = r_sh[N-1:0] - d_q;

        case (state_q)
            RUN: begin
                r_d   = fits ? t : r_sh[N-1:0];
                qw_d  = {qw_q[N-2:0], fits};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = qw_d;
                    rem_d   = r_d;
                end
            end
            default: begin
                state_d = IDLE;
                if (bus.load) begin
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quot_d  = '1;
                        rem_d   = bus.dividend[N-1:0];
                    end else if (bus.dividend[2*N-1:N] >= bus.divisor) begin
                        state_d = DONE;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = RUN;
                        r_d     = bus.dividend[2*N-1:N];
                        qw_d    = bus.dividend[N-1:0];
                        d_d     = bus.divisor;
                        cnt_d   = CW'(N);
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            qw_q    <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            qw_q    <= qw_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_shift_divider.sv
// Bench for shift_divider: arithmetic model checked every cycle plus directed
// literal checks on results, latency and control corner cases.
module tb_shift_divider;
    localparam int N = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    shift_divider_if #(.N(N)) bus ();
    shift_divider #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: cycles of work left, pending result, and the visible outputs.
    int m_left = 0;
    int m_q = 0, m_r = 0, p_q = 0, p_r = 0;
    bit m_done = 0, m_dbz = 0, m_ovf = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_left <= 0; m_done <= 0; m_q <= 0; m_r <= 0; m_dbz <= 0; m_ovf <= 0;
        end else begin
            m_done <= 0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_q <= p_q; m_r <= p_r; m_done <= 1;
                end
            end else if (bus.load) begin
                if (bus.divisor == 0) begin
                    m_q <= 2**N - 1; m_r <= int'(bus.dividend) % (2**N);
                    m_dbz <= 1; m_ovf <= 0; m_done <= 1;
                end else if ((int'(bus.dividend) / (2**N)) >= int'(bus.divisor)) begin
                    m_q <= 2**N - 1; m_r <= 0;
                    m_dbz <= 0; m_ovf <= 1; m_done <= 1;
                end else begin
                    p_q <= int'(bus.dividend) / int'(bus.divisor);
                    p_r <= int'(bus.dividend) % int'(bus.divisor);
                    m_left <= N; m_dbz <= 0; m_ovf <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", bus.busy, int'(m_left > 0));
            check("done", bus.done, m_done);
            check("quotient", bus.quotient, m_q);
            check("remainder", bus.remainder, m_r);
            check("div_by_zero", bus.div_by_zero, m_dbz);
            check("overflow", bus.overflow, m_ovf);
        end
    end

    task automatic start(input int dd, input int dv);
        bus.load     = 1'b1;
        bus.dividend = (2*N)'(dd);
        bus.divisor  = N'(dv);
    endtask

    // One operation; lat = edges after the load edge until done is seen.
    task automatic op(input string nm, input int dd, input int dv, input int eq,
                      input int er, input int edbz, input int eovf, input int elat,
                      input bit b2b, input int hold_q);
        int lat;
        bit got;
        if (!b2b) begin
            @(posedge clk); #2;
        end
        start(dd, dv);
        @(posedge clk); #2 bus.load = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                break;
            end
            if (hold_q >= 0) check({nm, "_hold_q"}, bus.quotient, hold_q);
            lat++;
        end
        check({nm, "_done_seen"}, got, 1);
        check({nm, "_latency"}, lat, elat);
        check({nm, "_q"}, bus.quotient, eq);
        check({nm, "_r"}, bus.remainder, er);
        check({nm, "_dbz"}, bus.div_by_zero, edbz);
        check({nm, "_ovf"}, bus.overflow, eovf);
    endtask

    initial begin
        int ndone;
        bus.load = 1'b0; bus.dividend = '0; bus.divisor = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_q", bus.quotient, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_flags", {bus.div_by_zero, bus.overflow}, 0);

        op("basic",   30,   6,  5,  0,  0, 0, N, 0, -1);
        op("nontriv", 1000, 37, 27, 1,  0, 0, N, 0, -1);
        op("maxq",    4031, 63, 63, 62, 0, 0, N, 0, -1);
        op("dbz",     100,  0,  63, 36, 1, 0, 0, 0, -1);
        op("ovf",     500,  6,  63, 0,  0, 1, 0, 0, -1);
        op("ovf_max", 4095, 63, 63, 0,  0, 1, 0, 0, -1);

        // Load raised in the third RUN cycle must be ignored.
        @(posedge clk); #2 start(30, 6);
        @(posedge clk); #2 bus.load = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2 start(1000, 37);
        @(posedge clk); #2 bus.load = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                check("ign_q", bus.quotient, 5);
                check("ign_r", bus.remainder, 0);
            end
        end
        check("ign_done_count", ndone, 1);

        // Second load issued in the DONE cycle of the first.
        op("b2b_first",  30,   6,  5,  0, 0, 0, N, 0, -1);
        op("b2b_second", 1000, 37, 27, 1, 0, 0, N, 1, 5);

        // Reset in the third RUN cycle aborts the operation.
        @(posedge clk); #2 start(30, 6);
        @(posedge clk); #2 bus.load = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        check("mrst_q", bus.quotient, 0);
        check("mrst_r", bus.remainder, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_done", bus.done, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("mrst_no_done", ndone, 0);
        op("after_rst", 30, 6, 5, 0, 0, 0, N, 0, -1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
